// File: rtl/dbi_decoder.sv
`default_nettype none
// ============================================================================
// Module   : dbi_decoder
// Purpose  : Bus-invert decoder with a 2-entry output FIFO, inverted-word
//            counter and optional encoding check (macro DBI_DECODER_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module dbi_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_was_inv,
    input  logic             clr,
    output logic [15:0]      inv_count,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_load_head;
    logic             w_load_tail;
    logic             w_shift;
    logic [WIDTH:0]   w_word;
    logic [WIDTH:0]   r_head;
    logic [WIDTH:0]   r_tail;
    logic [15:0]      r_inv_count;

    // Ready depends on registered state only, so no path from out_ready.
    assign in_ready    = (r_state != ST_FULL);
    assign out_valid   = (r_state != ST_EMPTY);
    assign w_push      = in_valid & in_ready;
    assign w_pop       = out_valid & out_ready;
    assign w_word      = {in_inv, (in_inv ? ~in_data : in_data)};
    assign out_data    = r_head[WIDTH-1:0];
    assign out_was_inv = r_head[WIDTH];
    assign inv_count   = r_inv_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_head = 1'b0;
        w_load_tail = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = ST_ONE;
                    w_load_head = 1'b1;
                end
            end
            ST_ONE: begin
                case ({w_push, w_pop})
                    2'b10: begin
                        w_state_nxt = ST_FULL;
                        w_load_tail = 1'b1;
                    end
                    2'b01: w_state_nxt = ST_EMPTY;
                    // Simultaneous push/pop replaces the single entry in place.
                    2'b11: w_load_head = 1'b1;
                    default: w_state_nxt = ST_ONE;
                endcase
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_nxt = ST_ONE;
                    w_shift     = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_load_head) begin
                r_head <= w_word;
            end else if (w_shift) begin
                r_head <= r_tail;
            end
            if (w_load_tail) begin
                r_tail <= w_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inv_count <= 16'h0000;
        end else if (clr) begin
            r_inv_count <= 16'h0000;
        end else if (w_push && in_inv && (r_inv_count != 16'hFFFF)) begin
            r_inv_count <= r_inv_count + 16'h0001;
        end
    end

`ifdef DBI_DECODER_CHECK_EN
    localparam int C_ONES_W = $clog2(WIDTH + 1);

    logic [C_ONES_W-1:0] w_ones;
    logic                r_err;

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ones = w_ones + C_ONES_W'(in_data[i]);
        end
    end

    // A valid encoder never sends more than half the bits set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (clr) begin
            r_err <= 1'b0;
        end else if (w_push && (w_ones > C_ONES_W'(WIDTH / 2))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dbi_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbi_decoder
// Purpose  : Self-checking bench for dbi_decoder against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbi_decoder;

    localparam int W = 8;
`ifdef DBI_DECODER_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_inv = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_was_inv;
    logic         clr = 1'b0;
    logic [15:0]  inv_count;
    logic         err;

    int checks = 0;
    int failures = 0;

    // Reference model: queue of {was_inv, decoded}, counter, sticky error.
    logic [W:0]   mq[$];
    int unsigned  mcnt = 0;
    bit           merr = 1'b0;

    dbi_decoder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_was_inv(out_was_inv),
        .clr(clr), .inv_count(inv_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        mcnt = 0;
        merr = 1'b0;
    endtask

    // Advance one clock; model follows the inputs held across the edge.
    task automatic step();
        bit acc, pop;
        @(posedge clk);
        acc = in_valid && (mq.size() < 2);
        pop = out_ready && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back({in_inv, (in_inv ? ~in_data : in_data)});
        if (clr) begin
            mcnt = 0;
            merr = 1'b0;
        end else begin
            if (acc && in_inv && mcnt < 65535) mcnt++;
            if (CHK_EN && acc && ($countones(in_data) > W / 2)) merr = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 8'h00 || out_was_inv !== 1'b0) begin failures++; $display("FAIL reset_out_data got=%h/%b exp=00/0", out_data, out_was_inv); end
        checks++; if (inv_count !== 16'h0 || err !== 1'b0) begin failures++; $display("FAIL reset_count_err got=%h/%b exp=0000/0", inv_count, err); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h0F; in_inv = 1'b1;
        step();
        in_valid = 1'b0; in_inv = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hF0 || out_was_inv !== 1'b1) begin failures++; $display("FAIL basic_out got=%b/%h/%b exp=1/f0/1", out_valid, out_data, out_was_inv); end
        checks++; if (inv_count !== 16'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", inv_count); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_full();
        out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0;
        in_data = 8'h01; step();
        in_data = 8'h02; step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        in_data = 8'h03; step();
        in_valid = 1'b0;
        checks++; if (out_data !== 8'h01 || out_valid !== 1'b1) begin failures++; $display("FAIL full_hold got=%h/%b exp=01/1", out_data, out_valid); end
        out_ready = 1'b1; step();
        checks++; if (out_data !== 8'h02 || in_ready !== 1'b1) begin failures++; $display("FAIL full_second got=%h/%b exp=02/1", out_data, in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_third_dropped got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; in_data = 8'h40;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'h41 + 8'(i);
            checks++; if (out_data !== 8'h40 + 8'(i)) begin failures++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, out_data, 8'h40 + 8'(i)); end
            step();
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_state_one[%0d] got=%b/%b exp=1/1", i, out_valid, in_ready); end
        end
        in_valid = 1'b0;
        checks++; if (out_data !== 8'h4A) begin failures++; $display("FAIL b2b_last got=%h exp=4a", out_data); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            in_inv    = 1'($urandom);
            in_data   = W'($urandom);
            clr       = 1'($urandom_range(0, 15) == 0);
            step();
            checks++; if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < 2)) begin failures++; $display("FAIL rand_flags[%0d] got=%b/%b exp=%b/%b", i, out_valid, in_ready, mq.size() != 0, mq.size() < 2); end
            if (mq.size() != 0) begin
                checks++; if ({out_was_inv, out_data} !== mq[0]) begin failures++; $display("FAIL rand_head[%0d] got=%h exp=%h", i, {out_was_inv, out_data}, mq[0]); end
            end
            checks++; if (inv_count !== 16'(mcnt) || err !== merr) begin failures++; $display("FAIL rand_count_err[%0d] got=%h/%b exp=%h/%b", i, inv_count, err, 16'(mcnt), merr); end
        end
        idle_inputs();
        out_ready = 1'b1; step(); step();
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        clr = 1'b1; step(); clr = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_inv = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            in_data = W'(i);
            step();
        end
        checks++; if (inv_count !== 16'hFFFE) begin failures++; $display("FAIL sat_preload got=%h exp=fffe", inv_count); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (inv_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", inv_count); end
        clr = 1'b1; in_data = 8'h11; step(); clr = 1'b0; in_valid = 1'b0;
        checks++; if (inv_count !== 16'h0000 || out_data !== 8'hEE || out_valid !== 1'b1) begin failures++; $display("FAIL sat_clr got=%h/%h/%b exp=0000/ee/1", inv_count, out_data, out_valid); end
        step();
        idle_inputs();
    endtask

    task automatic test_err();
        bit exp_err;
        clr = 1'b1; step(); clr = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err); end
        out_ready = 1'b1; in_valid = 1'b1; in_inv = 1'b1; in_data = 8'h0F;
        step();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_legal got=%b exp=0", err); end
        in_inv = 1'b0; in_data = 8'hF8;
        step();
        in_valid = 1'b0;
        exp_err = CHK_EN;
        checks++; if (err !== exp_err || err !== merr) begin failures++; $display("FAIL err_set got=%b exp=%b", err, exp_err); end
        step(); step();
        checks++; if (err !== exp_err) begin failures++; $display("FAIL err_sticky got=%b exp=%b", err, exp_err); end
        clr = 1'b1; step(); clr = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", err); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b1;
        in_data = 8'hA5; step();
        in_data = 8'h3C; step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL async_fill got=%b/%b exp=0/1", in_ready, out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL async_flags got=%b/%b exp=0/1", out_valid, in_ready); end
        checks++; if (out_data !== 8'h00 || out_was_inv !== 1'b0 || inv_count !== 16'h0) begin failures++; $display("FAIL async_clear got=%h/%b/%h exp=00/0/0000", out_data, out_was_inv, inv_count); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        in_valid = 1'b1; in_inv = 1'b0; in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin failures++; $display("FAIL async_first_accept got=%b/%h exp=1/5a", out_valid, out_data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_random();
        test_saturation();
        test_err();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
